// File: rtl/slv_spi.sv
// SPI peripheral: oversamples sclk/cs_n/mosi on clk, shifts rx words in and tx words out on miso.
// Latency: pin edges are acted on 3 clk after they occur; rx_byte/rx_vld follow the last sample edge by 1 clk.
// Backpressure: none on rx (rx_vld is a 1-cycle pulse); tx accepts via tx_vld/tx_rdy into a 1-deep holding register.
//
// Ports:
//   clk, arst_n           system clock (>= 8x sclk), async active-low reset
//   mode[1:0]             {CPOL, CPHA}; change only while cs_n is high
//   sclk, cs_n, mosi      asynchronous SPI pins from the master
//   miso                  serial data to the master (0 while idle)
//   tx_byte/tx_vld/tx_rdy word to transmit, handshake into the holding register
//   rx_byte/rx_vld        last complete received word, 1-cycle update pulse
//   busy                  frame active (synchronised cs_n low)
//   frame_err             1-cycle pulse when cs_n rises mid-word
module slv_spi #(
   parameter int             BUS     = 8,
   parameter logic [BUS-1:0] TX_IDLE = '0
) (
   input  logic           clk,
   input  logic           arst_n,
   input  logic [1:0]     mode,
   input  logic           sclk,
   input  logic           cs_n,
   input  logic           mosi,
   output logic           miso,
   input  logic [BUS-1:0] tx_byte,
   input  logic           tx_vld,
   output logic           tx_rdy,
   output logic [BUS-1:0] rx_byte,
   output logic           rx_vld,
   output logic           busy,
   output logic           frame_err
);

   localparam int CW = $clog2(BUS);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t         state_q, state_d;

   logic [2:0]     sclk_sync;
   logic [2:0]     cs_sync;
   logic [1:0]     mosi_sync;

   logic [BUS-1:0] tx_shift;
   logic [BUS-1:0] rx_shift;
   logic [CW-1:0]  bit_cnt;
   // Set whenever a fresh word sits in tx_shift whose MSB is already on
   // miso; the next shift event must leave it in place.
   logic           skip;

   logic [BUS-1:0] hold_q;
   logic           hold_full;

   // ------------------------------------------------------------------
   // Synchronisers. Index [1] is the synchronised value, [2] the delayed
   // copy for edge detection. mosi[1] is aligned with sclk_sync[1].
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sclk_sync <= 3'b111;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sclk};
         cs_sync   <= {cs_sync[1:0], cs_n};
         mosi_sync <= {mosi_sync[0], mosi};
      end
   end

   logic cpol, cpha;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic lead_ev, trail_ev, sample_ev, shift_ev;
   logic active, last_sample, load_word;
   logic [BUS-1:0] tx_next;
   logic [BUS-1:0] rx_word;

   assign cpol      = mode[1];
   assign cpha      = mode[0];
   assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
   assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
   assign cs_rise   =  cs_sync[1] & ~cs_sync[2];

   // Leading edge moves sclk away from its idle level (CPOL).
   assign lead_ev   = cpol ? sclk_fall : sclk_rise;
   assign trail_ev  = cpol ? sclk_rise : sclk_fall;
   assign sample_ev = cpha ? trail_ev : lead_ev;
   assign shift_ev  = cpha ? lead_ev  : trail_ev;

   assign active      = (state_q == ACTIVE);
   assign last_sample = sample_ev && (bit_cnt == CW'(BUS-1));
   // A new tx word enters tx_shift at frame start and at each word
   // boundary, but not when the frame is ending in the same cycle.
   assign load_word   = (!active && cs_fall) || (active && !cs_rise && last_sample);
   assign tx_next     = hold_full ? hold_q : TX_IDLE;
   assign rx_word     = {rx_shift[BUS-2:0], mosi_sync[1]};
   assign tx_rdy      = ~hold_full;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      miso    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) state_d = ACTIVE;
         end
         ACTIVE: begin
            busy = 1'b1;
            miso = tx_shift[BUS-1];
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Shift datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         skip      <= 1'b0;
         rx_byte   <= '0;
         rx_vld    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_vld    <= 1'b0;
         frame_err <= 1'b0;
         if (!active) begin
            if (cs_fall) begin
               tx_shift <= tx_next;
               rx_shift <= '0;
               bit_cnt  <= '0;
               // CPHA=0 already has the MSB out before the first sample;
               // CPHA=1 presents it on the first leading edge without shifting.
               skip     <= cpha;
            end
         end else if (cs_rise) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            skip     <= 1'b0;
            // A final sample coinciding with cs_n rising still completes.
            if (last_sample) begin
               rx_byte <= rx_word;
               rx_vld  <= 1'b1;
            end else if (bit_cnt != '0) begin
               frame_err <= 1'b1;
            end
         end else if (sample_ev) begin
            rx_shift <= rx_word;
            if (last_sample) begin
               bit_cnt  <= '0;
               rx_byte  <= rx_word;
               rx_vld   <= 1'b1;
               tx_shift <= tx_next;
               skip     <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else if (shift_ev) begin
            if (skip) skip     <= 1'b0;
            else      tx_shift <= tx_shift << 1;
         end
      end
   end

   // ------------------------------------------------------------------
   // One-deep tx holding register; survives cs_n rising.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hold_q    <= '0;
         hold_full <= 1'b0;
      end else if (load_word && hold_full) begin
         hold_full <= 1'b0;
      end else if (tx_vld && !hold_full) begin
         hold_q    <= tx_byte;
         hold_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_slv_spi.sv
module tb_slv_spi;

   localparam int HP = 4;   // sclk half-period in clk cycles

   logic       clk = 1'b0;
   logic       arst_n;
   logic [1:0] mode;
   logic       sclk, cs_n, mosi;
   logic       miso;
   logic [7:0] tx_byte;
   logic       tx_vld, tx_rdy;
   logic [7:0] rx_byte;
   logic       rx_vld, busy, frame_err;

   always #5 clk = ~clk;

   slv_spi #(.BUS(8), .TX_IDLE(8'hFF)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .mode      (mode),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .tx_byte   (tx_byte),
      .tx_vld    (tx_vld),
      .tx_rdy    (tx_rdy),
      .rx_byte   (rx_byte),
      .rx_vld    (rx_vld),
      .busy      (busy),
      .frame_err (frame_err)
   );

   int         n_chk  = 0;
   int         n_pass = 0;
   int         rx_cnt = 0;
   int         fe_cnt = 0;
   logic [7:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard: every rx_vld pulse pops the oldest expected word.
   always @(negedge clk) begin
      if (arst_n === 1'b1) begin
         if (rx_vld === 1'b1) begin
            rx_cnt++;
            if (sb_q.size() == 0) chk("rx_vld_unexpected", {31'b0, rx_vld}, 32'd0);
            else                  chk("rx_byte_sb", {24'b0, rx_byte}, {24'b0, sb_q.pop_front()});
         end
         if (frame_err === 1'b1) fe_cnt++;
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic write_tx(input logic [7:0] v);
      int w = 0;
      while (tx_rdy !== 1'b1 && w < 50) begin
         tick(1);
         w++;
      end
      chk("tx_rdy_wait", {31'b0, tx_rdy}, 32'd1);
      tx_byte = v;
      tx_vld  = 1'b1;
      tick(1);
      tx_vld  = 1'b0;
   endtask

   // Master side of one word (or a partial word of nbits), MSB first.
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic cpol, cpha;
      cpol = mode[1];
      cpha = mode[0];
      mi   = 8'h00;
      if (nbits == 8) sb_q.push_back(mo);
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = mo[7-i];
            tick(HP);
            mi   = {mi[6:0], miso};
            sclk = ~cpol;
            tick(HP);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[7-i];
            tick(HP);
            mi   = {mi[6:0], miso};
            sclk = cpol;
            tick(HP);
         end
      end
   endtask

   task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
      cs_n = 1'b0;
      tick(6);
      xfer(mo, 8, mi);
      tick(HP);
      cs_n = 1'b1;
      tick(10);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_miso"},      {31'b0, miso},      32'd0);
      chk({pfx, "_tx_rdy"},    {31'b0, tx_rdy},    32'd1);
      chk({pfx, "_rx_byte"},   {24'b0, rx_byte},   32'd0);
      chk({pfx, "_rx_vld"},    {31'b0, rx_vld},    32'd0);
      chk({pfx, "_busy"},      {31'b0, busy},      32'd0);
      chk({pfx, "_frame_err"}, {31'b0, frame_err}, 32'd0);
   endtask

   initial begin
      logic [7:0] mi;
      int r0, f0;

      arst_n = 1'b0; mode = 2'd0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_byte = 8'h00; tx_vld = 1'b0;
      tick(3);
      chk_reset_outputs("rst");
      arst_n = 1'b1;
      tick(5);

      // Mode 0, preloaded holding register
      write_tx(8'hA5);
      chk("m0_tx_rdy_full", {31'b0, tx_rdy}, 32'd0);
      r0 = rx_cnt;
      cs_n = 1'b0;
      tick(6);
      chk("m0_busy", {31'b0, busy}, 32'd1);
      chk("m0_tx_rdy_back", {31'b0, tx_rdy}, 32'd1);
      xfer(8'h3C, 8, mi);
      tick(HP);
      cs_n = 1'b1;
      tick(10);
      chk("m0_miso_word", {24'b0, mi}, 32'h0000_00A5);
      chk("m0_rx_cnt", rx_cnt - r0, 32'd1);
      chk("m0_rx_byte", {24'b0, rx_byte}, 32'h0000_003C);
      chk("m0_busy_idle", {31'b0, busy}, 32'd0);

      // Modes 1..3
      for (int m = 1; m < 4; m++) begin
         mode = m[1:0];
         sclk = mode[1];
         tick(8);
         write_tx(8'h81);
         r0 = rx_cnt;
         frame(8'h7E, mi);
         chk($sformatf("m%0d_miso_word", m), {24'b0, mi}, 32'h0000_0081);
         chk($sformatf("m%0d_rx_cnt", m), rx_cnt - r0, 32'd1);
         chk($sformatf("m%0d_rx_byte", m), {24'b0, rx_byte}, 32'h0000_007E);
      end

      // Back-to-back words in mode 0
      mode = 2'd0;
      sclk = 1'b0;
      tick(8);
      write_tx(8'hA5);
      r0 = rx_cnt;
      cs_n = 1'b0;
      tick(6);
      write_tx(8'h55);
      xfer(8'h12, 8, mi);
      chk("b2b_w0_miso", {24'b0, mi}, 32'h0000_00A5);
      xfer(8'h34, 8, mi);
      chk("b2b_w1_miso", {24'b0, mi}, 32'h0000_0055);
      tick(HP);
      cs_n = 1'b1;
      tick(10);
      chk("b2b_rx_cnt", rx_cnt - r0, 32'd2);
      chk("b2b_rx_byte", {24'b0, rx_byte}, 32'h0000_0034);

      // Empty holding register -> TX_IDLE
      chk("idle_tx_rdy", {31'b0, tx_rdy}, 32'd1);
      frame(8'h6B, mi);
      chk("idle_miso_word", {24'b0, mi}, 32'h0000_00FF);
      chk("idle_rx_byte", {24'b0, rx_byte}, 32'h0000_006B);

      // cs_n raised after 5 bits
      r0 = rx_cnt;
      f0 = fe_cnt;
      cs_n = 1'b0;
      tick(6);
      xfer(8'hF0, 5, mi);
      tick(HP);
      cs_n = 1'b1;
      tick(10);
      chk("abort_frame_err", fe_cnt - f0, 32'd1);
      chk("abort_rx_cnt", rx_cnt - r0, 32'd0);
      chk("abort_rx_byte", {24'b0, rx_byte}, 32'h0000_006B);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      frame(8'h99, mi);
      chk("after_abort_rx_byte", {24'b0, rx_byte}, 32'h0000_0099);
      chk("after_abort_rx_cnt", rx_cnt - r0, 32'd1);
      chk("after_abort_miso", {24'b0, mi}, 32'h0000_00FF);
      chk("after_abort_fe", fe_cnt - f0, 32'd1);

      // Asynchronous reset after 3 bits
      f0 = fe_cnt;
      cs_n = 1'b0;
      tick(6);
      write_tx(8'h42);
      chk("rst_mid_tx_rdy_full", {31'b0, tx_rdy}, 32'd0);
      xfer(8'hAA, 3, mi);
      arst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      cs_n = 1'b1;
      sclk = 1'b0;
      tick(3);
      arst_n = 1'b1;
      tick(5);
      r0 = rx_cnt;
      frame(8'hC3, mi);
      chk("post_rst_rx_byte", {24'b0, rx_byte}, 32'h0000_00C3);
      chk("post_rst_rx_cnt", rx_cnt - r0, 32'd1);
      chk("post_rst_miso", {24'b0, mi}, 32'h0000_00FF);
      chk("post_rst_fe", fe_cnt - f0, 32'd0);

      chk("sb_drain", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/slv_spi.md
Name: slv_spi

Overview:
- SPI peripheral (slave) end of the serial link. It pairs with the team's SPI master at the other end of the same SCLK/MOSI/MISO wires.
- Oversamples SCLK, CS_N and MOSI on the local system clock, shifts received bits into a BUS-wide word and shifts transmit data out on MISO.
- Supports SPI modes 0-3 and back-to-back words within one chip-select assertion.
- Sits between the pads and a register or command block that consumes rx words and supplies tx words.

Parameters:
- BUS, 8, word width in bits (>= 2).
- TX_IDLE, 0, BUS-bit word shifted out when no tx word is pending at word start.

Ports:
- clk  input  1  system clock; must be at least 8x sclk frequency.
- arst_n  input  1  asynchronous active-low reset.
- mode  input  2  SPI mode; mode[1]=CPOL, mode[0]=CPHA. Change only while cs_n is high.
- sclk  input  1  SPI clock from master (asynchronous to clk).
- cs_n  input  1  active-low chip select from master (asynchronous).
- mosi  input  1  serial data from master (asynchronous).
- miso  output  1  serial data to master.
- tx_byte  input  BUS  word to transmit.
- tx_vld  input  1  tx_byte valid.
- tx_rdy  output  1  holding register empty; a transfer occurs when tx_vld && tx_rdy on a clk edge.
- rx_byte  output  BUS  last complete received word; holds until the next word completes.
- rx_vld  output  1  one-cycle pulse when rx_byte updates.
- busy  output  1  high while a frame is active (synchronised cs_n low).
- frame_err  output  1  one-cycle pulse when cs_n deasserts mid-word.

Behaviour:
- Reset values: miso=0, tx_rdy=1, rx_byte=0, rx_vld=0, busy=0, frame_err=0. Shift registers, bit counter and holding register clear; state=IDLE.
- Synchronisers:
  - sclk, cs_n and mosi each pass through a 2-flop synchroniser (sclk and cs_n reset to 1, mosi to 0).
  - A third sclk flop provides edge detect.
  - A pin edge is acted on 3 clk cycles after it occurs. Each sclk half-period must be >= 4 clk.
- Edge mapping:
  - Leading edge: the sclk transition away from CPOL. Trailing edge: the transition back to CPOL.
  - CPHA=0: sample mosi on the leading edge; shift miso on the trailing edge.
  - CPHA=1: shift miso on the leading edge; sample mosi on the trailing edge.
  - Sampling uses the synchronised mosi, which is aligned with the synchronised sclk.
- States:
  - IDLE: miso=0 and busy=0. On a synchronised cs_n falling edge: load the tx shift register, bit_cnt=0, go to ACTIVE.
  - ACTIVE: busy=1 and miso = tx_shift[BUS-1].
- tx word load:
  - A word is taken from the holding register if it is full (tx_rdy=0), and tx_rdy then returns to 1 the next cycle.
  - If the holding register is empty, TX_IDLE is loaded.
  - CPHA=0: the MSB must be on miso before the first leading edge, so the load happens at cs_n fall.
  - CPHA=1: the tx register also loads at cs_n fall; the first leading edge presents the MSB and does not shift.
- Sample events:
  - Each sample edge shifts the synchronised mosi into rx_shift LSB (MSB-first) and increments bit_cnt.
  - On the BUS-th sample: rx_byte <= the completed word next cycle, rx_vld=1 for 1 cycle, bit_cnt wraps to 0.
  - At the word boundary the next tx word is loaded, from the holding register or TX_IDLE.
- Shift events: tx_shift <<= 1, except at a word boundary, where the new word is loaded instead.
- cs_n rising (synchronised) in ACTIVE:
  - If bit_cnt != 0: discard the partial rx word, pulse frame_err for 1 cycle, no rx_vld.
  - In all cases return to IDLE and clear the shift registers.
  - The holding register is preserved.
- Simultaneous events:
  - cs_n rising and the final sample edge in the same cycle: the sample completes (rx_vld), no frame_err.
  - tx_vld write in the same cycle the holding register is consumed: tx_rdy was 0, so no write is accepted. This cycle is not a conflict.
- Sclk edges while in IDLE are ignored.
- Mode changes while busy=1 are unsupported; behaviour is unspecified until the next IDLE.
- Asynchronous reset mid-frame aborts immediately to the reset values. The next frame requires a fresh cs_n fall.
- rx_vld has no backpressure. The consumer must accept it in the pulse cycle; a missed word is overwritten.

Test Plan:
- Mode 0, BUS=8: holding=0xA5 preloaded; master sends 0x3C with half-period 4 clk -> miso bits 1,0,1,0,0,1,0,1; rx_byte=0x3C with one rx_vld pulse; tx_rdy returns to 1.
- Modes 1, 2, 3 each: tx 0x81, master sends 0x7E -> rx_byte=0x7E; master captures 0x81.
- Back-to-back: cs_n held low for 16 sclk; holding reloaded with 0x55 after the first word -> master receives 0xA5 then 0x55; two rx_vld pulses; rx_byte sequence 0x12, 0x34.
- Empty holding register with TX_IDLE=0xFF -> master receives 0xFF; rx still correct.
- cs_n raised after 5 bits -> frame_err pulse, no rx_vld, rx_byte keeps its prior value. The next full frame with 0x99 succeeds.
- arst_n asserted after 3 bits -> all outputs at reset values immediately. A subsequent frame 0xC3 is received correctly.
